// File: rtl/ultrasound_pkg.sv
// Shared types and default constants for the ultrasonic ranging blocks
// (burst sequencer and the PWM ADC receive path).
package ultrasound_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_BLANK,
        ST_LISTEN,
        ST_DONE
    } us_state_e;

    localparam int unsigned HALF_PERIOD_DEF = 312;
    localparam int unsigned PULSES_DEF      = 8;
    localparam int unsigned BLANK_CYC_DEF   = 25000;
    localparam int unsigned TIMEOUT_CYC_DEF = 750000;
    localparam int unsigned TOF_W_DEF       = 20;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ultrasound_burst_sequencer_if.sv
// Host/transducer/receiver signal bundle of the burst sequencer.
// master = measurement host side, slave = sequencer.
interface ultrasound_burst_sequencer_if #(
    parameter int unsigned TOF_W = ultrasound_pkg::TOF_W_DEF
) ();

    logic             start;
    logic             echo_in;
    logic             busy;
    logic             tx_en;
    logic             tx_out;
    logic             adc_en;
    logic             done;
    logic             timeout;
    logic [TOF_W-1:0] tof;

    modport master (
        output start, echo_in,
        input  busy, tx_en, tx_out, adc_en, done, timeout, tof
    );

    modport slave (
        input  start, echo_in,
        output busy, tx_en, tx_out, adc_en, done, timeout, tof
    );

endinterface

// File: rtl/us_carrier_gen.sv
// Carrier burst generator: 2*PULSES half-periods of HALF_PERIOD cycles each,
// starting high; flags the final cycle of the burst.
module us_carrier_gen
    import ultrasound_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = HALF_PERIOD_DEF,
    parameter int unsigned PULSES      = PULSES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic enable,
    output logic tx_out,
    output logic last
);

    localparam int unsigned HW    = cnt_width(HALF_PERIOD);
    localparam int unsigned EDGES = 2 * PULSES;
    localparam int unsigned EW    = cnt_width(EDGES);
    localparam logic [HW-1:0] HALF_MAX = HW'(HALF_PERIOD - 1);
    localparam logic [EW-1:0] EDGE_MAX = EW'(EDGES - 1);

    logic [HW-1:0] half_cnt_q, half_cnt_d;
    logic [EW-1:0] edge_cnt_q, edge_cnt_d;
    logic          tx_q, tx_d;
    logic          half_end;

    // Counters rest at zero and the carrier low whenever the burst is not running.
    always_comb begin
        half_end   = (half_cnt_q == HALF_MAX);
        last       = enable && half_end && (edge_cnt_q == EDGE_MAX);
        half_cnt_d = '0;
        edge_cnt_d = '0;
        tx_d       = 1'b0;
        if (run) begin
            tx_d = 1'b1;
        end else if (enable && !last) begin
            if (half_end) begin
                edge_cnt_d = edge_cnt_q + 1'b1;
                tx_d       = ~tx_q;
            end else begin
                half_cnt_d = half_cnt_q + 1'b1;
                edge_cnt_d = edge_cnt_q;
                tx_d       = tx_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt_q <= '0;
            edge_cnt_q <= '0;
            tx_q       <= 1'b0;
        end else begin
            half_cnt_q <= half_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            tx_q       <= tx_d;
        end
    end

    assign tx_out = tx_q;

endmodule

// File: rtl/ultrasound_burst_sequencer.sv
// One ultrasonic ranging measurement: TX burst, receiver blanking, echo listen.
// Define ECHO_SYNC_EN to pass echo_in through a two-flop synchronizer.
module ultrasound_burst_sequencer
    import ultrasound_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = HALF_PERIOD_DEF,
    parameter int unsigned PULSES      = PULSES_DEF,
    parameter int unsigned BLANK_CYC   = BLANK_CYC_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned TOF_W       = TOF_W_DEF
) (
    input logic                          clk,
    input logic                          rst_n,
    ultrasound_burst_sequencer_if.slave  bus
);

    localparam int unsigned BW = cnt_width(BLANK_CYC);
    localparam logic [BW-1:0]    BLANK_MAX = BW'(BLANK_CYC - 1);
    localparam logic [TOF_W-1:0] TOF_MAX   = TOF_W'(TIMEOUT_CYC - 1);

    us_state_e        state_q, state_d;
    logic [TOF_W-1:0] tof_cnt_q, tof_cnt_d;
    logic [BW-1:0]    blank_cnt_q, blank_cnt_d;
    logic [TOF_W-1:0] tof_q, tof_d;
    logic             timeout_q, timeout_d;
    logic             run;
    logic             tx_active;
    logic             carrier_last;
    logic             echo_det;

`ifdef ECHO_SYNC_EN
    logic echo_meta_q, echo_meta_d;
    logic echo_sync_q, echo_sync_d;

    always_comb begin
        echo_meta_d = bus.echo_in;
        echo_sync_d = echo_meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta_q <= 1'b0;
            echo_sync_q <= 1'b0;
        end else begin
            echo_meta_q <= echo_meta_d;
            echo_sync_q <= echo_sync_d;
        end
    end

    assign echo_det = echo_sync_q;
`else
    assign echo_det = bus.echo_in;
`endif

    assign tx_active = (state_q == ST_TX);

    us_carrier_gen #(
        .HALF_PERIOD (HALF_PERIOD),
        .PULSES      (PULSES)
    ) u_carrier (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (run),
        .enable (tx_active),
        .tx_out (bus.tx_out),
        .last   (carrier_last)
    );

    always_comb begin
        state_d     = state_q;
        tof_cnt_d   = tof_cnt_q;
        blank_cnt_d = blank_cnt_q;
        tof_d       = tof_q;
        timeout_d   = timeout_q;
        run         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    run       = 1'b1;
                    state_d   = ST_TX;
                    tof_cnt_d = '0;
                    tof_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_TX: begin
                tof_cnt_d   = tof_cnt_q + 1'b1;
                blank_cnt_d = '0;
                if (carrier_last) state_d = ST_BLANK;
            end
            ST_BLANK: begin
                tof_cnt_d   = tof_cnt_q + 1'b1;
                blank_cnt_d = blank_cnt_q + 1'b1;
                if (blank_cnt_q == BLANK_MAX) state_d = ST_LISTEN;
            end
            ST_LISTEN: begin
                // An echo on the final window cycle still counts as a hit.
                if (echo_det) begin
                    state_d   = ST_DONE;
                    tof_d     = tof_cnt_q;
                    timeout_d = 1'b0;
                end else if (tof_cnt_q == TOF_MAX) begin
                    state_d   = ST_DONE;
                    tof_d     = TOF_MAX;
                    timeout_d = 1'b1;
                end else begin
                    tof_cnt_d = tof_cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tof_cnt_q   <= '0;
            blank_cnt_q <= '0;
            tof_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tof_cnt_q   <= tof_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            tof_q       <= tof_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.tx_en   = tx_active;
    assign bus.adc_en  = (state_q == ST_LISTEN);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.timeout = timeout_q;
    assign bus.tof     = tof_q;

endmodule

// File: tb/tb_ultrasound_burst_sequencer.sv
// Directed, table-driven bench for ultrasound_burst_sequencer (small parameters).
// Honors ECHO_SYNC_EN when the design is built with it.
module tb_ultrasound_burst_sequencer;

    localparam int unsigned HP      = 4;
    localparam int unsigned NP      = 2;
    localparam int unsigned BLANK   = 10;
    localparam int unsigned TMO     = 100;
    localparam int unsigned TOF_W   = 20;
    localparam int          TXC     = 16;
    localparam int          LISTEN0 = 26;

    typedef struct {
        string name;
        int    lo;
        int    hi;
        int    slo;
        int    shi;
        bit    hold;
        bit    chained;
        int    tof_ns;
        bit    to_ns;
        int    tof_s;
        bit    to_s;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    vec_t vecs[8];

    always #5 clk = ~clk;

    ultrasound_burst_sequencer_if #(.TOF_W(TOF_W)) bus ();

    ultrasound_burst_sequencer #(
        .HALF_PERIOD (HP),
        .PULSES      (NP),
        .BLANK_CYC   (BLANK),
        .TIMEOUT_CYC (TMO),
        .TOF_W       (TOF_W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [4:0] outs();
        return {bus.busy, bus.tx_en, bus.tx_out, bus.adc_en, bus.done};
    endfunction

    // Cycle c of a run is the cycle in which the sequencer's tof_cnt equals c.
    task automatic run_meas(input vec_t v);
        int d;
        bit to_exp;
        int dones;
        logic [4:0] e_outs;
`ifdef ECHO_SYNC_EN
        d      = v.tof_s;
        to_exp = v.to_s;
`else
        d      = v.tof_ns;
        to_exp = v.to_ns;
`endif
        dones = 0;
        if (!v.chained) begin
            @(negedge clk);
            bus.start   = 1'b1;
            bus.echo_in = 1'b0;
        end
        @(posedge clk);
        for (int c = 0; c <= d + 2; c++) begin
            @(negedge clk);
            bus.echo_in = (c >= v.lo && c <= v.hi);
            bus.start   = v.hold || (c >= v.slo && c <= v.shi);
            if (c < TXC)          e_outs = {1'b1, 1'b1, ((c / HP) % 2 == 0), 1'b0, 1'b0};
            else if (c < LISTEN0) e_outs = 5'b10000;
            else if (c <= d)      e_outs = 5'b10010;
            else if (c == d + 1)  e_outs = 5'b10001;
            else                  e_outs = 5'b00000;
            check($sformatf("%s outs c=%0d", v.name, c), {27'd0, outs()}, {27'd0, e_outs});
            if (bus.done) dones++;
            if (c == 0) begin
                check($sformatf("%s tof_clear", v.name), bus.tof, '0);
                check($sformatf("%s timeout_clear", v.name), {31'd0, bus.timeout}, 32'd0);
            end
            if (c >= d + 1) begin
                check($sformatf("%s tof c=%0d", v.name, c), bus.tof, d);
                check($sformatf("%s timeout c=%0d", v.name, c), {31'd0, bus.timeout}, {31'd0, to_exp});
            end
        end
        check($sformatf("%s done_count", v.name), dones, 1);
        if (!v.hold) begin
            bus.start   = 1'b0;
            bus.echo_in = 1'b0;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check($sformatf("%s idle_after i=%0d", v.name, i), {27'd0, outs()}, 32'd0);
            end
        end
    endtask

    initial begin
        // name, echo lo..hi, start lo..hi, hold, chained, tof/to (raw), tof/to (synced)
        vecs[0] = '{"window",    40, 45, -9, -9, 1'b0, 1'b0, 40, 1'b0, 42, 1'b0};
        vecs[1] = '{"early",      2, 22, -9, -9, 1'b0, 1'b0, 99, 1'b1, 99, 1'b1};
        vecs[2] = '{"first_lst", 26, 26, -9, -9, 1'b0, 1'b0, 26, 1'b0, 28, 1'b0};
        vecs[3] = '{"last_lst",  99, 99, -9, -9, 1'b0, 1'b0, 99, 1'b0, 99, 1'b1};
        vecs[4] = '{"busy_start",60, 80, 17, 22, 1'b0, 1'b0, 60, 1'b0, 62, 1'b0};
        vecs[5] = '{"b2b_first", 30, 30, -9, -9, 1'b1, 1'b0, 30, 1'b0, 32, 1'b0};
        vecs[6] = '{"b2b_second",50, 55, -9, -9, 1'b0, 1'b1, 50, 1'b0, 52, 1'b0};
        vecs[7] = '{"no_echo",   -9, -9, -9, -9, 1'b0, 1'b0, 99, 1'b1, 99, 1'b1};

        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.echo_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outs", {27'd0, outs()}, 32'd0);
        check("reset tof", bus.tof, '0);
        check("reset timeout", {31'd0, bus.timeout}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("idle outs i=%0d", i), {27'd0, outs()}, 32'd0);
        end

        foreach (vecs[i]) run_meas(vecs[i]);

        // Abort in the middle of TX: outputs must drop without a clock edge.
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_abort outs", {27'd0, outs()}, 32'b11100);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort async outs", {27'd0, outs()}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("abort hold i=%0d", i), {27'd0, outs()}, 32'd0);
        end
        rst_n = 1'b1;
        run_meas(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got timeout, expected end of test");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/ultrasound_burst_sequencer.md
# ultrasound_burst_sequencer

Sequences one ultrasonic ranging measurement: it emits a burst of carrier pulses to the transducer driver, blanks the receiver while ringing decays, then enables the PWM ADC front end and waits for the echo comparator. It returns a time-of-flight cycle count or a timeout flag. It sits between the measurement host logic and the transducer driver / PWM ADC receive path.

## Interface
- HALF_PERIOD, 312: clk cycles per carrier half-period (25 MHz clk, about 40 kHz).
- PULSES, 8: full carrier periods per burst.
- BLANK_CYC, 25000: receiver blanking cycles after the burst.
- TIMEOUT_CYC, 750000: maximum measurement length in cycles, counted from the first TX cycle.
- TOF_W, 20: width of the time-of-flight result.
- Parameter constraints:
  - 2·PULSES·HALF_PERIOD + BLANK_CYC < TIMEOUT_CYC ≤ 2^TOF_W.
  - HALF_PERIOD ≥ 1; PULSES ≥ 1; BLANK_CYC ≥ 1.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  measurement request; sampled in IDLE only.
- echo_in  in  1  echo comparator output (from the PWM ADC path).
- busy  out  1  high in every state except IDLE.
- tx_en  out  1  transducer driver enable; high in TX only.
- tx_out  out  1  carrier square wave; 0 outside TX.
- adc_en  out  1  PWM ADC receive enable; high in LISTEN only.
- done  out  1  one-cycle result strobe.
- timeout  out  1  result flag; valid with done and held until the next start.
- tof  out  TOF_W  time of flight in clk cycles; held until the next start.

## Operation
- States: IDLE, TX, BLANK, LISTEN, DONE.
- IDLE:
  - start=1 → TX.
  - tof_cnt, tof and timeout are cleared at the same edge.
- TX:
  - tx_en=1.
  - tx_out starts high and toggles every HALF_PERIOD cycles.
  - Runs exactly 2·PULSES·HALF_PERIOD cycles, then → BLANK.
- BLANK:
  - All drive and receive enables are low.
  - Runs exactly BLANK_CYC cycles, then → LISTEN.
- LISTEN:
  - adc_en=1.
  - Echo detected → DONE: tof ← tof_cnt, timeout ← 0.
  - Otherwise, tof_cnt = TIMEOUT_CYC−1 → DONE: tof ← TIMEOUT_CYC−1, timeout ← 1.
  - Echo and timeout in the same cycle: echo wins, timeout=0.
- DONE:
  - done=1 for one cycle, then → IDLE.
- tof_cnt:
  - 0 in the first TX cycle.
  - Increments every cycle in TX, BLANK and LISTEN.
  - Never wraps, guaranteed by the parameter constraints.
- echo_in is ignored in IDLE, TX, BLANK and DONE.
- start is ignored while busy. No queuing.

## Timing
- Reset: all outputs 0; state IDLE; all counters 0.
- Reset asserted mid-measurement aborts immediately: tx_en and tx_out drop asynchronously. No done is issued.
- start high at edge k:
  - busy=1, tx_en=1 and tx_out=1 from cycle k+1.
  - tof_cnt=0 in cycle k+1.
- TX occupies tof_cnt 0 … 2·PULSES·HALF_PERIOD−1.
- BLANK follows for BLANK_CYC cycles.
- First LISTEN cycle: tof_cnt = 2·PULSES·HALF_PERIOD + BLANK_CYC.
- Echo sampled high at an edge in LISTEN with tof_cnt=N:
  - Next cycle: state DONE, done=1, tof=N.
  - busy=0 one cycle later.
- start held high continuously: a new measurement begins the cycle after DONE (back-to-back).

## Configuration
- ECHO_SYNC_EN defined:
  - echo_in passes through a two-flop synchronizer before detection.
  - Reported tof is 2 higher than for the same raw echo edge.
- ECHO_SYNC_EN undefined:
  - echo_in is used directly.
  - The source must already be synchronous to clk.

## Structure
- Shared package ultrasound_pkg holds:
  - the state enum typedef;
  - default constants for HALF_PERIOD, PULSES, BLANK_CYC, TIMEOUT_CYC, TOF_W, shared with the PWM ADC blocks.
- One sub-module, us_carrier_gen:
  - half-period counter, pulse counter and tx_out toggle;
  - inputs: run, enable;
  - output: last-cycle flag, used by the FSM to leave TX.

## Test plan
Bench parameters: HALF_PERIOD=4, PULSES=2, BLANK_CYC=10, TIMEOUT_CYC=100, ECHO_SYNC_EN undefined unless stated.

- Reset then idle:
  - Stimulus: rst_n low for 3 cycles, then release; start=0.
  - Required: all outputs 0; no done.
- Echo in window:
  - Stimulus: start pulse; echo_in high when tof_cnt=40.
  - Required: tx_out pattern is 1111000011110000 over 16 cycles; adc_en rises at tof_cnt=26; done one cycle later with tof=40, timeout=0.
- Early echo:
  - Stimulus: echo_in high during TX and BLANK only.
  - Required: ignored; completes with timeout=1, tof=99.
- Start while busy:
  - Stimulus: start pulses during BLANK.
  - Required: no restart; exactly one done per accepted start.
- Reset mid-measurement:
  - Stimulus: rst_n low during TX.
  - Required: tx_en and tx_out 0 immediately; no done; after reset release, a fresh start gives correct tof.
- With ECHO_SYNC_EN:
  - Stimulus: same echo timing as the echo-in-window case.
  - Required: tof=42.
